// File: rtl/exc_pkg.sv
// Shared constants for the execute-stage exception/status unit.
// Holds opcode/func encodings and the cause-code enumeration.
// No logic, so there is no latency and no backpressure.
package exc_pkg;

   // Execute-stage opcode and ALU func encodings
   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] FN_ADD  = 5'b00000;
   localparam logic [4:0] FN_SUB  = 5'b00001;
   localparam logic [4:0] FN_MUL  = 5'b00110;
   localparam logic [4:0] FN_DIV  = 5'b00111;

   // Width of a raw cause code before zero-extension to DATA_W
   localparam int CODE_W = 3;

   typedef enum logic [CODE_W-1:0] {
      EXC_NONE = 3'd0,
      EXC_ADD  = 3'd1,
      EXC_ADDI = 3'd2,
      EXC_SUB  = 3'd3,
      EXC_MUL  = 3'd4,
      EXC_DIV  = 3'd5
   } exc_code_e;

endpackage

// File: rtl/exc_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: push is refused while full unless a pop happens in the same cycle; pop while empty is ignored.
//
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   push, push_data   write request and data
//   pop               read request (advances head)
//   head              oldest entry (undefined content while empty)
//   full, empty       status flags
//   count             occupancy 0..DEPTH
module exc_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign head  = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO can still accept
   // a push when it is being drained on that edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// Execute-stage exception decode feeding a pending-cause FIFO drained to the $r30 status write port.
// Latency: cause detected in cycle N appears on status_en/status_writeReg in cycle N+1 when the FIFO was empty.
// Backpressure: codes wait in the FIFO until status_ack; a cause arriving while full with no pop is dropped and flagged.
//
// Ports:
//   clock, reset             rising-edge clock, async active-low reset
//   insn_valid, flush        execute-stage qualifiers (flush squashes the cause)
//   opcode, func_field       instruction decode fields
//   ovf, div0                ALU/multiplier overflow and divide-by-zero flags
//   status_ack               writeback accepted the current status write
//   clear_drop               clears the sticky dropped flag
//   status_en                status write request (FIFO non-empty)
//   status_writeReg          head cause code, 0 when empty
//   last_code                most recently acknowledged code
//   pending                  FIFO occupancy
//   dropped                  sticky lost-cause flag
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4,
   parameter int MULDIV_EN = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       insn_valid,
   input  logic [4:0]                 opcode,
   input  logic [4:0]                 func_field,
   input  logic                       ovf,
   input  logic                       div0,
   input  logic                       flush,
   input  logic                       status_ack,
   input  logic                       clear_drop,
   output logic                       status_en,
   output logic [DATA_W-1:0]          status_writeReg,
   output logic [DATA_W-1:0]          last_code,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       dropped
);

   exc_code_e         cause;
   logic              cause_vld;
   logic [DATA_W-1:0] cause_word;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_fire;
   logic              drop_evt;

   // Cause decode. Each opcode/func pair checks only its own flag, so ovf on
   // a div or div0 on anything but a div never raises a cause.
   always_comb begin
      cause = EXC_NONE;
      if (insn_valid && !flush) begin
         if (opcode == OP_ALU) begin
            case (func_field)
               FN_ADD:  if (ovf) cause = EXC_ADD;
               FN_SUB:  if (ovf) cause = EXC_SUB;
               FN_MUL:  if ((MULDIV_EN != 0) && ovf)  cause = EXC_MUL;
               FN_DIV:  if ((MULDIV_EN != 0) && div0) cause = EXC_DIV;
               default: cause = EXC_NONE;
            endcase
         end else if (opcode == OP_ADDI) begin
            if (ovf) cause = EXC_ADDI;
         end
      end
   end

   assign cause_vld  = (cause != EXC_NONE);
   assign cause_word = {{(DATA_W-CODE_W){1'b0}}, cause};

   // Ack without a request is ignored because pop_fire needs a non-empty FIFO.
   assign pop_fire = status_ack && !fifo_empty;
   assign drop_evt = cause_vld && fifo_full && !pop_fire;

   exc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cause_vld),
      .push_data (cause_word),
      .pop       (pop_fire),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (pending)
   );

   assign status_en       = !fifo_empty;
   assign status_writeReg = fifo_empty ? '0 : fifo_head;

   // A new drop takes priority over clear_drop in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_code <= '0;
         dropped   <= 1'b0;
      end else begin
         if (pop_fire) begin
            last_code <= fifo_head;
         end
         if (drop_evt) begin
            dropped <= 1'b1;
         end else if (clear_drop) begin
            dropped <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: two instances (mul/div decode on and off) share stimulus.
// A queue-style model per instance is checked every cycle; directed scenarios add literal checks.
module tb_exception_ctrl;

   localparam int DEPTH = 4;

   logic       clock;
   logic       reset;
   logic       insn_valid;
   logic [4:0] opcode;
   logic [4:0] func_field;
   logic       ovf;
   logic       div0;
   logic       flush;
   logic       status_ack;
   logic       clear_drop;

   logic        a_en,   b_en;
   logic [31:0] a_wr,   b_wr;
   logic [31:0] a_last, b_last;
   logic [2:0]  a_pend, b_pend;
   logic        a_drop, b_drop;

   int total = 0;
   int bad   = 0;

   exception_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .MULDIV_EN(1)) dut_a (
      .clock(clock), .reset(reset), .insn_valid(insn_valid), .opcode(opcode),
      .func_field(func_field), .ovf(ovf), .div0(div0), .flush(flush),
      .status_ack(status_ack), .clear_drop(clear_drop),
      .status_en(a_en), .status_writeReg(a_wr), .last_code(a_last),
      .pending(a_pend), .dropped(a_drop)
   );

   exception_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .MULDIV_EN(0)) dut_b (
      .clock(clock), .reset(reset), .insn_valid(insn_valid), .opcode(opcode),
      .func_field(func_field), .ovf(ovf), .div0(div0), .flush(flush),
      .status_ack(status_ack), .clear_drop(clear_drop),
      .status_en(b_en), .status_writeReg(b_wr), .last_code(b_last),
      .pending(b_pend), .dropped(b_drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: index 0 = mul/div enabled, index 1 = disabled.
   int mq    [2][DEPTH];
   int mcnt  [2] = '{0, 0};
   int mlast [2] = '{0, 0};
   int mdrop [2] = '{0, 0};

   function automatic int exp_cause(input bit md, input bit v, input logic [4:0] op,
                                    input logic [4:0] fn, input bit o, input bit d, input bit f);
      if (!v || f) return 0;
      if (op == 5'd5) return o ? 2 : 0;
      if (op != 5'd0) return 0;
      case (fn)
         5'd0: return o ? 1 : 0;
         5'd1: return o ? 3 : 0;
         5'd6: return (md && o) ? 4 : 0;
         5'd7: return (md && d) ? 5 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int m = 0; m < 2; m++) begin
            mcnt[m]  = 0;
            mlast[m] = 0;
            mdrop[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            int  c;
            bit  dropnow;
            c = exp_cause(m == 0, insn_valid, opcode, func_field, ovf, div0, flush);
            dropnow = 1'b0;
            if (mcnt[m] > 0 && status_ack) begin
               mlast[m] = mq[m][0];
               for (int k = 0; k < DEPTH-1; k++) mq[m][k] = mq[m][k+1];
               mcnt[m]--;
            end
            if (c != 0) begin
               if (mcnt[m] < DEPTH) begin
                  mq[m][mcnt[m]] = c;
                  mcnt[m]++;
               end else begin
                  dropnow = 1'b1;
               end
            end
            if (dropnow) mdrop[m] = 1;
            else if (clear_drop) mdrop[m] = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mhead(input int m);
      return (mcnt[m] > 0) ? mq[m][0] : 0;
   endfunction

   task automatic compare_all();
      chk("a_en",   32'(a_en),   32'(mcnt[0] > 0));
      chk("a_wr",   a_wr,        32'(mhead(0)));
      chk("a_last", a_last,      32'(mlast[0]));
      chk("a_pend", 32'(a_pend), 32'(mcnt[0]));
      chk("a_drop", 32'(a_drop), 32'(mdrop[0]));
      chk("b_en",   32'(b_en),   32'(mcnt[1] > 0));
      chk("b_wr",   b_wr,        32'(mhead(1)));
      chk("b_last", b_last,      32'(mlast[1]));
      chk("b_pend", 32'(b_pend), 32'(mcnt[1]));
      chk("b_drop", 32'(b_drop), 32'(mdrop[1]));
   endtask

   // Outputs are compared at the falling edge; inputs change 1 time unit after the rising edge.
   task automatic step();
      @(negedge clock);
      compare_all();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [4:0] fn, input bit o, input bit d,
                        input bit f, input bit a, input bit c);
      insn_valid = 1'b1; opcode = op; func_field = fn; ovf = o; div0 = d;
      flush = f; status_ack = a; clear_drop = c;
      step();
   endtask

   task automatic nop(input bit a, input bit c);
      insn_valid = 1'b0; opcode = 5'd0; func_field = 5'd0; ovf = 1'b0; div0 = 1'b0;
      flush = 1'b0; status_ack = a; clear_drop = c;
      step();
   endtask

   initial begin
      reset = 1'b1;
      insn_valid = 1'b0; opcode = '0; func_field = '0; ovf = 1'b0; div0 = 1'b0;
      flush = 1'b0; status_ack = 1'b0; clear_drop = 1'b0;
      #2 reset = 1'b0;
      repeat (3) step();
      chk("rst_en",   32'(a_en),   32'd0);
      chk("rst_wr",   a_wr,        32'd0);
      chk("rst_last", a_last,      32'd0);
      chk("rst_pend", 32'(a_pend), 32'd0);
      chk("rst_drop", 32'(a_drop), 32'd0);
      reset = 1'b1;
      nop(0, 0);

      // First-cause latency with ack held
      issue(5'd0, 5'd0, 1, 0, 0, 1, 0);
      chk("lat_en", 32'(a_en), 32'd1);
      chk("lat_wr", a_wr,      32'd1);
      nop(1, 0);
      chk("lat_last", a_last,      32'd1);
      chk("lat_pend", 32'(a_pend), 32'd0);
      chk("lat_en0",  32'(a_en),   32'd0);

      // Three back-to-back causes, then drain in order
      issue(5'd5, 5'd9, 1, 0, 0, 0, 0);
      issue(5'd0, 5'd1, 1, 0, 0, 0, 0);
      issue(5'd0, 5'd7, 0, 1, 0, 0, 0);
      chk("burst_pend",   32'(a_pend), 32'd3);
      chk("burst_head",   a_wr,        32'd2);
      chk("burst_b_pend", 32'(b_pend), 32'd2);
      nop(1, 0); chk("pop1", a_last, 32'd2);
      nop(1, 0); chk("pop2", a_last, 32'd3);
      nop(1, 0); chk("pop3", a_last, 32'd5);
      chk("pop_empty", 32'(a_en), 32'd0);

      // Full: drop, then full with simultaneous pop
      repeat (DEPTH) issue(5'd0, 5'd0, 1, 0, 0, 0, 0);
      chk("full_pend", 32'(a_pend), 32'd4);
      issue(5'd0, 5'd1, 1, 0, 0, 0, 0);
      chk("drop_set",  32'(a_drop), 32'd1);
      chk("drop_pend", 32'(a_pend), 32'd4);
      chk("drop_head", a_wr,        32'd1);
      nop(0, 1);
      chk("drop_clr", 32'(a_drop), 32'd0);
      issue(5'd0, 5'd1, 1, 0, 0, 1, 0);
      chk("fullpop_pend", 32'(a_pend), 32'd4);
      chk("fullpop_drop", 32'(a_drop), 32'd0);
      chk("fullpop_last", a_last,      32'd1);
      repeat (DEPTH) nop(1, 0);
      chk("fullpop_tail", a_last, 32'd3);
      chk("fullpop_en",   32'(a_en), 32'd0);

      // Suppressed or non-causing instructions
      issue(5'd0, 5'd0, 1, 0, 1, 0, 0); chk("flush_en",  32'(a_en), 32'd0);
      issue(5'd0, 5'd0, 0, 1, 0, 0, 0); chk("noovf_en",  32'(a_en), 32'd0);
      issue(5'd2, 5'd0, 1, 0, 0, 0, 0); chk("badop_en",  32'(a_en), 32'd0);
      issue(5'd0, 5'd7, 1, 0, 0, 0, 0); chk("divovf_en", 32'(a_en), 32'd0);
      issue(5'd0, 5'd7, 0, 1, 0, 0, 0);
      chk("nomd_b_en", 32'(b_en), 32'd0);
      chk("md_a_wr",   a_wr,      32'd5);
      nop(1, 0);

      // Clear and drop in the same cycle: set wins
      repeat (DEPTH) issue(5'd0, 5'd0, 1, 0, 0, 0, 0);
      issue(5'd0, 5'd0, 1, 0, 0, 0, 1);
      chk("setwins", 32'(a_drop), 32'd1);
      nop(0, 1);
      chk("clear_alone", 32'(a_drop), 32'd0);
      repeat (DEPTH) nop(1, 0);

      // Asynchronous reset with three codes queued
      issue(5'd0, 5'd0, 1, 0, 0, 0, 0);
      issue(5'd0, 5'd1, 1, 0, 0, 0, 0);
      issue(5'd5, 5'd0, 1, 0, 0, 0, 0);
      chk("pre_rst_pend", 32'(a_pend), 32'd3);
      #1 reset = 1'b0;
      #1;
      chk("arst_en",   32'(a_en),   32'd0);
      chk("arst_pend", 32'(a_pend), 32'd0);
      chk("arst_wr",   a_wr,        32'd0);
      nop(0, 0);
      nop(0, 0);
      reset = 1'b1;
      nop(0, 0);
      nop(1, 0);
      chk("post_rst_en",   32'(a_en), 32'd0);
      chk("post_rst_last", a_last,    32'd0);

      // Randomized traffic; ack density varies by phase so the FIFO fills and drains
      for (int i = 0; i < 3000; i++) begin
         int r;
         int ackpct;
         ackpct = ((i / 300) % 2 == 0) ? 70 : 15;
         r = $urandom_range(0, 3);
         opcode = (r == 1) ? 5'd5 : (r == 3) ? 5'($urandom) : 5'd0;
         r = $urandom_range(0, 4);
         func_field = (r == 0) ? 5'd0 : (r == 1) ? 5'd1 : (r == 2) ? 5'd6 :
                      (r == 3) ? 5'd7 : 5'($urandom);
         insn_valid = ($urandom_range(0, 7) != 0);
         ovf        = $urandom_range(0, 1) == 1;
         div0       = $urandom_range(0, 1) == 1;
         flush      = ($urandom_range(0, 7) == 0);
         status_ack = ($urandom_range(0, 99) < ackpct);
         clear_drop = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end else begin
            step();
         end
      end
      nop(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
